// File: rtl/spi_txn_arbiter.sv
// Arbitrates three requesters onto one SPI master: LOAD, then RUN, then DONE; RX byte captured at end of RUN.
// Latency REQ->ACK = 1+LOAD_CYCLES+XFER_CYCLES (1 on reject); REQ held until ACK. SPI_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module spi_txn_arbiter #(
    parameter int LOAD_CYCLES = 2,
    parameter int XFER_CYCLES = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_req,
    input  logic [23:0] i_req_data,
    input  logic [5:0]  i_req_slave,
    input  logic [5:0]  i_req_mode,
    output logic [2:0]  o_ack,
    output logic [7:0]  o_rx_data,
    output logic        o_err,
    output logic        o_busy,
    output logic [2:0]  o_mode,
    output logic [2:0]  o_ss_in,
    output logic [7:0]  o_data_m,
    output logic        o_read_memory_m,
    output logic        o_start,
    input  logic [7:0]  i_out_main_master
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [7:0] LOAD_RELOAD = 8'(LOAD_CYCLES - 1);
    localparam logic [7:0] XFER_RELOAD = 8'(XFER_CYCLES - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [1:0]  r_win;
    logic [7:0]  r_data;
    logic [1:0]  r_slave;
    logic [1:0]  r_mode;
    logic        r_err;
    logic [7:0]  r_rx;
    logic [2:0]  r_mask;

    logic [2:0]  w_req;
    logic        w_any;
    logic [1:0]  w_win;
    logic [7:0]  w_data;
    logic [1:0]  w_slave;
    logic [1:0]  w_mode;
    logic [2:0]  w_ack_vec;
    logic [2:0]  w_ss_lat;
    logic        w_cnt_zero;

    // The just-acknowledged requester sits out the IDLE cycle right after DONE.
    assign w_req      = i_req & ~r_mask;
    assign w_any      = |w_req;
    assign w_ack_vec  = 3'b001 << r_win;
    assign w_cnt_zero = (r_cnt == 8'd0);
    assign o_rx_data  = r_rx;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic [1:0] r_ptr;

    always_comb begin
        w_win = 2'd0;
        case (r_ptr)
            2'd0: begin
                if (w_req[1])      w_win = 2'd1;
                else if (w_req[2]) w_win = 2'd2;
                else               w_win = 2'd0;
            end
            2'd1: begin
                if (w_req[2])      w_win = 2'd2;
                else if (w_req[0]) w_win = 2'd0;
                else               w_win = 2'd1;
            end
            default: begin
                if (w_req[0])      w_win = 2'd0;
                else if (w_req[1]) w_win = 2'd1;
                else               w_win = 2'd2;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ptr <= 2'd2;
        else if (r_state == S_IDLE && w_any)
            r_ptr <= w_win;
    end
`else
    always_comb begin
        w_win = 2'd0;
        if (w_req[0])      w_win = 2'd0;
        else if (w_req[1]) w_win = 2'd1;
        else               w_win = 2'd2;
    end
`endif

    always_comb begin
        w_data  = i_req_data[7:0];
        w_slave = i_req_slave[1:0];
        w_mode  = i_req_mode[1:0];
        case (w_win)
            2'd1: begin
                w_data  = i_req_data[15:8];
                w_slave = i_req_slave[3:2];
                w_mode  = i_req_mode[3:2];
            end
            2'd2: begin
                w_data  = i_req_data[23:16];
                w_slave = i_req_slave[5:4];
                w_mode  = i_req_mode[5:4];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ss_lat = 3'b111;
        case (r_slave)
            2'd1:    w_ss_lat = 3'b110;
            2'd2:    w_ss_lat = 3'b101;
            2'd3:    w_ss_lat = 3'b011;
            default: w_ss_lat = 3'b111;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        o_ack           = 3'b000;
        o_err           = 1'b0;
        o_busy          = 1'b1;
        o_mode          = 3'b000;
        o_ss_in         = 3'b111;
        o_data_m        = 8'h00;
        o_read_memory_m = 1'b0;
        o_start         = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (w_any)
                    w_next = (w_slave == 2'd0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                o_mode          = {1'b0, r_mode};
                o_ss_in         = w_ss_lat;
                o_data_m        = r_data;
                o_read_memory_m = 1'b1;
                if (w_cnt_zero)
                    w_next = S_RUN;
            end
            S_RUN: begin
                o_mode   = {1'b0, r_mode};
                o_ss_in  = w_ss_lat;
                o_data_m = r_data;
                o_start  = 1'b1;
                if (w_cnt_zero)
                    w_next = S_DONE;
            end
            S_DONE: begin
                o_ack  = w_ack_vec;
                o_err  = r_err;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= 8'd0;
            r_win   <= 2'd0;
            r_data  <= 8'h00;
            r_slave <= 2'd0;
            r_mode  <= 2'd0;
            r_err   <= 1'b0;
            r_rx    <= 8'h00;
            r_mask  <= 3'b000;
        end else begin
            r_mask <= (r_state == S_DONE) ? w_ack_vec : 3'b000;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win   <= w_win;
                        r_data  <= w_data;
                        r_slave <= w_slave;
                        r_mode  <= w_mode;
                        r_err   <= (w_slave == 2'd0);
                        r_cnt   <= LOAD_RELOAD;
                    end
                end
                S_LOAD: begin
                    if (w_cnt_zero)
                        r_cnt <= XFER_RELOAD;
                    else
                        r_cnt <= r_cnt - 8'd1;
                end
                S_RUN: begin
                    if (w_cnt_zero)
                        r_rx <= i_out_main_master;
                    else
                        r_cnt <= r_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
